// File: rtl/md_issue_buf.sv
// md_issue_buf: FIFO of HI/LO operations in front of the multiply/divide unit.
// Requests {op,a,b} are queued and issued one at a time; long ops (mult/div)
// are held on the output bus until the unit reports it is (nearly) idle.
// Optional feature macro: MD_ISSUE_BYPASS_EN lets a request that lands in an
// empty, idle buffer go straight to ISSUE on the edge that accepts it.
module md_issue_buf #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_op,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    output logic                     in_ready,
    input  logic [7:0]               md_busy,
    output logic [7:0]               out_op,
    output logic [31:0]              out_a,
    output logic [31:0]              out_b,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pending,
    output logic                     illegal_op
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [7:0] OP_MULT = 8'd24;
    localparam logic [7:0] OP_DIVU = 8'd27;
    localparam logic [7:0] OP_MTLO = 8'd29;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } md_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    md_req_t         mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   cnt_nxt;
    md_req_t         head;
    md_req_t         in_req;
    logic            legal, accept, push, pop;
    logic            head_long, remain;

    assign in_req    = '{op: in_op, a: in_a, b: in_b};
    assign legal     = (in_op >= OP_MULT) && (in_op <= OP_MTLO);
    assign in_ready  = (count < CW'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign head      = mem[rd_ptr];
    assign head_long = (head.op <= OP_DIVU);
    assign cnt_nxt   = count + CW'(push) - CW'(pop);
    assign remain    = (cnt_nxt != '0);

    // Next-state and pop decision; pop only ever happens from ISSUE or HOLD,
    // where the head entry is guaranteed to be present.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nxt = ISSUE;
                end
`ifdef MD_ISSUE_BYPASS_EN
                else if (push && (md_busy == 8'd0)) begin
                    state_nxt = ISSUE;
                end
`endif
            end
            ISSUE: begin
                if (head_long) begin
                    state_nxt = HOLD;
                end else begin
                    pop       = 1'b1;
                    state_nxt = remain ? ISSUE : IDLE;
                end
            end
            HOLD: begin
                if (md_busy < 8'd2) begin
                    pop       = 1'b1;
                    state_nxt = remain ? ISSUE : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register; reset abandons any in-flight op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= cnt_nxt;
        end
    end

    // Entry storage; contents are only meaningful where count says so.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_req;
        end
    end

    // One-cycle pulse for an accepted request carrying a non-HI/LO opcode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= accept && !legal;
        end
    end

    // The head is visible only while issuing or holding; otherwise a clean nop.
    always_comb begin
        out_op = 8'd0;
        out_a  = 32'd0;
        out_b  = 32'd0;
        if (state != IDLE) begin
            out_op = head.op;
            out_a  = head.a;
            out_b  = head.b;
        end
    end

    assign pending = (count != '0) || (state != IDLE);

    a_count_bound: assert property (@(posedge clk) disable iff (!reset)
        count <= CW'(DEPTH));
    a_busy_has_entry: assert property (@(posedge clk) disable iff (!reset)
        (state != IDLE) |-> (count != '0));

endmodule

// File: tb/tb_md_issue_buf.sv
// Bench for md_issue_buf: reset values, a cycle table of the main sequences,
// hand-written full-buffer / reset-in-HOLD / latency cases, and a random run
// scored against an in-order queue plus a simple multiply/divide unit model.
module tb_md_issue_buf;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef MD_ISSUE_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          clk, reset;
    logic          in_valid;
    logic [7:0]    in_op;
    logic [31:0]   in_a, in_b;
    logic          in_ready;
    logic [7:0]    md_busy;
    logic [7:0]    out_op;
    logic [31:0]   out_a, out_b;
    logic [CW-1:0] count;
    logic          pending, illegal_op;

    md_issue_buf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .in_ready(in_ready), .md_busy(md_busy),
        .out_op(out_op), .out_a(out_a), .out_b(out_b),
        .count(count), .pending(pending), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Unit model: a mult occupies the bus 6 cycles, a div 11; busy counts down
    // from the cycle after the issue and the buffer may release at busy<=1.
    logic [7:0] busy;
    assign md_busy = busy;
    always @(posedge clk or negedge reset) begin
        if (!reset) busy <= 8'd0;
        else if (busy != 8'd0) busy <= busy - 8'd1;
        else if (out_op >= 8'd24 && out_op <= 8'd27) busy <= (out_op <= 8'd25) ? 8'd5 : 8'd10;
    end

    // Scoreboard: accepted legal requests must issue in order, exactly once,
    // stay stable while the unit is busy, and the bus is all-zero when idle.
    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;
    req_t q[$];
    req_t cur;
    logic ill_exp;
    int   issued = 0;

    always @(posedge clk) begin
        if (!reset) begin
            q.delete();
            ill_exp = 1'b0;
        end else begin
            chk("illegal_pulse", illegal_op, ill_exp);
            if (md_busy != 8'd0) begin
                chk("hold_op", out_op, cur.op);
                chk("hold_a", out_a, cur.a);
                chk("hold_b", out_b, cur.b);
            end else if (out_op != 8'd0) begin
                if (q.size() == 0) begin
                    chk("spurious_issue", out_op, 0);
                end else begin
                    cur = q.pop_front();
                    issued++;
                    chk("issue_op", out_op, cur.op);
                    chk("issue_a", out_a, cur.a);
                    chk("issue_b", out_b, cur.b);
                end
            end else begin
                chk("nop_operands", out_a | out_b, 0);
            end
            ill_exp = in_valid && in_ready && !(in_op >= 8'd24 && in_op <= 8'd29);
            if (in_valid && in_ready && in_op >= 8'd24 && in_op <= 8'd29)
                q.push_back('{op: in_op, a: in_a, b: in_b});
        end
    end

    typedef struct {
        bit          v;
        logic [7:0]  op;
        logic [31:0] a, b;
        int          ecnt;
        logic [7:0]  eop;
        logic [31:0] ea, eb;
        bit          eill;
    } vec_t;
    vec_t tbl[$];

    function automatic void row(bit v, logic [7:0] op, logic [31:0] a, logic [31:0] b,
                                int ecnt, logic [7:0] eop, logic [31:0] ea, logic [31:0] eb, bit eill);
        vec_t t;
        t.v = v; t.op = op; t.a = a; t.b = b;
        t.ecnt = ecnt; t.eop = eop; t.ea = ea; t.eb = eb; t.eill = eill;
        tbl.push_back(t);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_op = 8'd0; in_a = 32'd0; in_b = 32'd0;
    endtask

    task automatic wait_idle();
        int n;
        idle_in();
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!pending && q.size() == 0 && md_busy == 8'd0) break;
        end
        chk("drain_timeout", (n >= 300) ? 1 : 0, 0);
        chk("drain_queue_empty", q.size(), 0);
        chk("drain_count", count, 0);
        cyc();
    endtask

    // Push one request into an idle, empty buffer and check its issue cycle.
    task automatic lat_chk(input string nm, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        cyc();
        idle_in();
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk(nm, out_op, (k == LAT) ? op : 8'd0);
            if (k == LAT) chk({nm, "_a"}, out_a, a);
            cyc();
        end
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, e;
        idle_in();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_out_op", out_op, 0);
        chk("rst_pending", pending, 0);
        chk("rst_illegal", illegal_op, 0);
        reset = 1'b1;
        cyc();

        // mult(7,-2): 1 ISSUE + 5 HOLD, then nop and pending low
        row(1, 24, 7, 32'hFFFFFFFE, 0, 0, 0, 0, 0);
        if (LAT == 2) row(0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) row(0, 0, 0, 0, 1, 24, 7, 32'hFFFFFFFE, 0);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // illegal opcode 30: one pulse, nothing stored or issued
        row(1, 30, 9, 9, 0, 0, 0, 0, 0);
        row(0, 0, 0, 0, 0, 0, 0, 0, 1);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // mtlo, mthi, div back-to-back
`ifdef MD_ISSUE_BYPASS_EN
        row(1, 29, 32'h1234, 0, 0, 0, 0, 0, 0);
        row(1, 28, 32'h5678, 0, 1, 29, 32'h1234, 0, 0);
        row(1, 26, 100, 7, 1, 28, 32'h5678, 0, 0);
`else
        row(1, 29, 32'h1234, 0, 0, 0, 0, 0, 0);
        row(1, 28, 32'h5678, 0, 1, 0, 0, 0, 0);
        row(1, 26, 100, 7, 2, 29, 32'h1234, 0, 0);
        row(0, 0, 0, 0, 2, 28, 32'h5678, 0, 0);
`endif
        for (int i = 0; i < 11; i++) row(0, 0, 0, 0, 1, 26, 100, 7, 0);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            in_valid = tbl[i].v; in_op = tbl[i].op; in_a = tbl[i].a; in_b = tbl[i].b;
            @(negedge clk);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].ecnt);
            chk($sformatf("tbl%0d_ready", i), in_ready, (tbl[i].ecnt < DEPTH) ? 1 : 0);
            chk($sformatf("tbl%0d_out_op", i), out_op, tbl[i].eop);
            chk($sformatf("tbl%0d_out_a", i), out_a, tbl[i].ea);
            chk($sformatf("tbl%0d_out_b", i), out_b, tbl[i].eb);
            chk($sformatf("tbl%0d_illegal", i), illegal_op, tbl[i].eill);
            chk($sformatf("tbl%0d_pending", i), pending,
                (tbl[i].ecnt != 0 || tbl[i].eop != 0) ? 1 : 0);
            cyc();
        end
        wait_idle();

        // Full buffer while a div holds: div + 3 more fill DEPTH, rest held off
        in_valid = 1'b1; in_op = 26; in_a = 50; in_b = 3;
        cyc();
        idle_in();
        repeat (LAT) cyc();
        idx = 0;
        for (int c = LAT + 1; c <= LAT + 9; c++) begin
            in_valid = 1'b1; in_op = 25; in_a = idx; in_b = idx + 1;
            @(negedge clk);
            e = (c - LAT < DEPTH) ? c - LAT : DEPTH;
            chk("full_count", count, e);
            chk("full_ready", in_ready, (e < DEPTH) ? 1 : 0);
            if (in_ready) idx++;
            cyc();
        end
        chk("full_accepted", idx, DEPTH - 1);
        wait_idle();

        // Reset in the middle of a div HOLD; the div must never reappear
        in_valid = 1'b1; in_op = 27; in_a = 11; in_b = 22;
        cyc();
        idle_in();
        repeat (LAT + 3) cyc();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("midrst_out_op", out_op, 0);
            chk("midrst_out_a", out_a, 0);
            chk("midrst_count", count, 0);
            chk("midrst_pending", pending, 0);
            chk("midrst_ready", in_ready, 1);
            chk("midrst_illegal", illegal_op, 0);
            cyc();
        end
        reset = 1'b1;
        cyc();
        lat_chk("post_rst_mult", 24, 3, 5);
        lat_chk("lat_multu", 25, 2, 3);

        // Random traffic scored by the queue model
        for (int n = 0; n < 600; n++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 9))
                0, 1:    in_op = 24 + 8'($urandom_range(0, 1));
                2:       in_op = 26 + 8'($urandom_range(0, 1));
                3, 4, 5: in_op = 28;
                6, 7:    in_op = 29;
                8:       in_op = 30;
                default: in_op = 8'($urandom_range(0, 23));
            endcase
            in_a = $urandom;
            in_b = $urandom;
            cyc();
        end
        wait_idle();
        chk("issued_nonzero", (issued > 20) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
